// File: rtl/sb_disjoint_reg.sv
// Disjoint switch box: every output track picks the same-numbered track from one of
// the other three sides, either combinationally or through a per-track register.
module sb_disjoint_reg #(
  parameter int WIDTH      = 7,
  parameter int NUM_TRACKS = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [31:0]                   config_addr,
  input  logic [31:0]                   config_data,
  input  logic                          config_en,
  output logic [31:0]                   read_data,
  input  logic [NUM_TRACKS*WIDTH-1:0]   in_north,
  input  logic [NUM_TRACKS*WIDTH-1:0]   in_south,
  input  logic [NUM_TRACKS*WIDTH-1:0]   in_east,
  input  logic [NUM_TRACKS*WIDTH-1:0]   in_west,
  output logic [NUM_TRACKS*WIDTH-1:0]   out_north,
  output logic [NUM_TRACKS*WIDTH-1:0]   out_south,
  output logic [NUM_TRACKS*WIDTH-1:0]   out_east,
  output logic [NUM_TRACKS*WIDTH-1:0]   out_west
);

  localparam int NUM_WORDS = (4 * NUM_TRACKS * 3 + 31) / 32;
  localparam int CFG_BITS  = 32 * NUM_WORDS;

  logic [31:0]          cfg_r [NUM_WORDS];
  logic [CFG_BITS-1:0]  cfg_s;
  logic [7:0]           word_idx_s;
  logic                 unused_addr_s;
  logic [31:0]          read_data_s;
  logic [WIDTH-1:0]     track_in_s  [4][NUM_TRACKS];
  logic [WIDTH-1:0]     track_out_s [4][NUM_TRACKS];

  assign word_idx_s    = config_addr[7:0];
  assign unused_addr_s = ^config_addr[31:8];

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_cfg_flat
    assign cfg_s[32*k +: 32] = cfg_r[k];
  end

  for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_pack
    assign track_in_s[0][t] = in_north[t*WIDTH +: WIDTH];
    assign track_in_s[1][t] = in_south[t*WIDTH +: WIDTH];
    assign track_in_s[2][t] = in_east[t*WIDTH +: WIDTH];
    assign track_in_s[3][t] = in_west[t*WIDTH +: WIDTH];
    assign out_north[t*WIDTH +: WIDTH] = track_out_s[0][t];
    assign out_south[t*WIDTH +: WIDTH] = track_out_s[1][t];
    assign out_east[t*WIDTH +: WIDTH]  = track_out_s[2][t];
    assign out_west[t*WIDTH +: WIDTH]  = track_out_s[3][t];
  end

  // Config word storage; out-of-range indices are silently dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        cfg_r[k] <= 32'd0;
      end
    end else begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (config_en && (word_idx_s == 8'(k))) begin
          cfg_r[k] <= config_data;
        end
      end
    end
  end

  // Readback mux: an OR of one-hot terms, so unmatched indices read 0.
  always_comb begin
    read_data_s = 32'd0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      read_data_s = read_data_s | ((word_idx_s == 8'(k)) ? cfg_r[k] : 32'd0);
    end
  end

  assign read_data = read_data_s;

  for (genvar s = 0; s < 4; s++) begin : g_side
    // Candidate sides are the other three, in ascending side code.
    localparam logic [1:0] C0 = (s == 0) ? 2'd1 : 2'd0;
    localparam logic [1:0] C1 = (s <= 1) ? 2'd2 : 2'd1;
    localparam logic [1:0] C2 = (s <= 2) ? 2'd3 : 2'd2;

    for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_track
      localparam int O = s * NUM_TRACKS + t;

      logic [1:0]       sel_s;
      logic             reg_en_s;
      logic [WIDTH-1:0] pick_s;
      logic [WIDTH-1:0] pipe_r;

      assign sel_s    = cfg_s[3*O +: 2];
      assign reg_en_s = cfg_s[3*O + 2];

      // Source selection for this output track; sel 3 forces zero.
      always_comb begin
        pick_s = {WIDTH{1'b0}};
        case (sel_s)
          2'd0:    pick_s = track_in_s[C0][t];
          2'd1:    pick_s = track_in_s[C1][t];
          2'd2:    pick_s = track_in_s[C2][t];
          default: pick_s = {WIDTH{1'b0}};
        endcase
      end

      // Pipeline stage captures every cycle, so enabling it shows a fresh value.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pipe_r <= {WIDTH{1'b0}};
        end else begin
          pipe_r <= pick_s;
        end
      end

      assign track_out_s[s][t] = reg_en_s ? pipe_r : pick_s;
    end
  end

endmodule

// File: tb/tb_sb_disjoint_reg.sv
// Directed bench for sb_disjoint_reg: a table of combinational routes plus
// hand-written sequences for registered paths, bounds and async reset.
module tb_sb_disjoint_reg;

  logic        clk;
  logic        reset;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        config_en;
  logic [31:0] read_data;
  logic [55:0] in_north, in_south, in_east, in_west;
  logic [55:0] out_north, out_south, out_east, out_west;

  int errors;
  int checks;

  typedef struct {
    logic [7:0]  idx;
    logic [31:0] data;
    int          side;
    int          trk;
    logic [6:0]  exp_out;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  sb_disjoint_reg dut (
    .clk(clk), .reset(reset),
    .config_addr(config_addr), .config_data(config_data),
    .config_en(config_en), .read_data(read_data),
    .in_north(in_north), .in_south(in_south), .in_east(in_east), .in_west(in_west),
    .out_north(out_north), .out_south(out_south), .out_east(out_east), .out_west(out_west)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] get_out(int side, int trk);
    logic [6:0] v;
    v = 7'd0;
    case (side)
      0: v = out_north[trk*7 +: 7];
      1: v = out_south[trk*7 +: 7];
      2: v = out_east[trk*7 +: 7];
      3: v = out_west[trk*7 +: 7];
      default: v = 7'd0;
    endcase
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_trk(input int side, input int trk, input logic [6:0] v);
    case (side)
      0: in_north[trk*7 +: 7] = v;
      1: in_south[trk*7 +: 7] = v;
      2: in_east[trk*7 +: 7]  = v;
      3: in_west[trk*7 +: 7]  = v;
      default: ;
    endcase
  endtask

  task automatic set_all(input logic [6:0] n, input logic [6:0] s,
                         input logic [6:0] e, input logic [6:0] w);
    for (int t = 0; t < 8; t++) begin
      set_trk(0, t, n);
      set_trk(1, t, s);
      set_trk(2, t, e);
      set_trk(3, t, w);
    end
  endtask

  // Present a write before a rising edge; returns #1 after that edge.
  task automatic write_word(input logic [7:0] idx, input logic [31:0] data);
    @(negedge clk);
    config_addr = {24'd0, idx};
    config_data = data;
    config_en   = 1'b1;
    @(posedge clk);
    #1;
    config_en = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [7:0] idx, input logic [31:0] exp);
    config_addr = {24'd0, idx};
    #1;
    check(name, read_data, exp);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    config_addr = 32'd0;
    config_data = 32'd0;
    config_en = 1'b0;
    in_north = 56'd0;
    in_south = 56'd0;
    in_east  = 56'd0;
    in_west  = 56'd0;

    //                 idx    data            side trk exp_out rd
    vecs[0] = '{8'd0, 32'h0000_0001, 0, 0, 7'd30, 32'h0000_0001};
    vecs[1] = '{8'd0, 32'h0000_0000, 0, 0, 7'd20, 32'h0000_0000};
    vecs[2] = '{8'd0, 32'h0000_0002, 0, 0, 7'd40, 32'h0000_0002};
    vecs[3] = '{8'd0, 32'h0000_0003, 0, 0, 7'd0,  32'h0000_0003};
    vecs[4] = '{8'd2, 32'h0000_0020, 2, 7, 7'd20, 32'h0000_0020};
    vecs[5] = '{8'd2, 32'h0000_0040, 2, 7, 7'd40, 32'h0000_0040};
    vecs[6] = '{8'd2, 32'h0000_0100, 3, 0, 7'd20, 32'h0000_0100};
    vecs[7] = '{8'd1, 32'h0000_0100, 1, 5, 7'd40, 32'h0000_0100};
    vecs[8] = '{8'd3, 32'hFFFF_FFFF, 1, 5, 7'd40, 32'h0000_0000};
    vecs[9] = '{8'd1, 32'h0000_0000, 1, 5, 7'd10, 32'h0000_0000};

    // Reset state
    #2;
    for (int i = 0; i < 4; i++) begin
      read_check($sformatf("reset_rd%0d", i), 8'(i), 32'd0);
    end
    set_trk(1, 3, 7'd5);
    #1;
    check("reset_route_n3", {25'd0, get_out(0, 3)}, 32'd5);
    @(negedge clk);
    reset = 1'b1;

    // Table of combinational routes
    set_all(7'd10, 7'd20, 7'd30, 7'd40);
    for (int i = 0; i < 10; i++) begin
      write_word(vecs[i].idx, vecs[i].data);
      check($sformatf("vec%0d_out", i), {25'd0, get_out(vecs[i].side, vecs[i].trk)},
            {25'd0, vecs[i].exp_out});
      check($sformatf("vec%0d_rd", i), read_data, vecs[i].exp_rd);
    end

    // Registered route: first edge shows value captured with the old config
    set_trk(3, 0, 7'd34);
    write_word(8'd0, 32'h0000_0000);
    check("reg_pre_comb", {25'd0, get_out(0, 0)}, 32'd20);
    write_word(8'd0, 32'h0000_0006);
    check("reg_enable_edge", {25'd0, get_out(0, 0)}, 32'd20);
    @(posedge clk); #1;
    check("reg_west34", {25'd0, get_out(0, 0)}, 32'd34);
    set_trk(3, 0, 7'd9);
    #1;
    check("reg_hold34", {25'd0, get_out(0, 0)}, 32'd34);
    @(posedge clk); #1;
    check("reg_west9", {25'd0, get_out(0, 0)}, 32'd9);

    // Constant-zero select with all inputs high
    set_all(7'h7F, 7'h7F, 7'h7F, 7'h7F);
    write_word(8'd2, 32'h0000_0060);
    check("sel3_e7", {25'd0, get_out(2, 7)}, 32'd0);
    check("sel0_e6", {25'd0, get_out(2, 6)}, 32'h7F);
    check("sel0_w0", {25'd0, get_out(3, 0)}, 32'h7F);

    // Readback and sel3+reg_en on word1
    write_word(8'd1, 32'h0007_0070);
    check("w1_rd", read_data, 32'h0007_0070);
    check("s4_old_capture", {25'd0, get_out(1, 4)}, 32'h7F);
    @(posedge clk); #1;
    check("s4_reg_zero", {25'd0, get_out(1, 4)}, 32'd0);
    check("e0_reg_zero", {25'd0, get_out(2, 0)}, 32'd0);

    // Out-of-range write
    write_word(8'd5, 32'hFFFF_FFFF);
    read_check("oob_rd5", 8'd5, 32'd0);
    read_check("oob_rd0", 8'd0, 32'h0000_0006);
    read_check("oob_rd1", 8'd1, 32'h0007_0070);
    read_check("oob_rd2", 8'd2, 32'h0000_0060);

    // Async reset mid-operation with a pending write
    set_trk(1, 0, 7'h11);
    set_trk(3, 0, 7'h22);
    set_trk(2, 0, 7'h33);
    @(posedge clk); #1;
    check("pre_rst_reg", {25'd0, get_out(0, 0)}, 32'h22);
    @(negedge clk);
    config_addr = 32'd0;
    config_data = 32'h0000_0001;
    config_en   = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("rst_n0_comb", {25'd0, get_out(0, 0)}, 32'h11);
    check("rst_s4_comb", {25'd0, get_out(1, 4)}, 32'h7F);
    for (int i = 0; i < 4; i++) begin
      read_check($sformatf("rst_rd%0d", i), 8'(i), 32'd0);
    end
    config_addr = 32'd0;
    @(posedge clk); #1;
    check("rst_write_lost", read_data, 32'd0);
    @(negedge clk);
    config_en = 1'b0;
    reset = 1'b1;
    write_word(8'd0, 32'h0000_0001);
    check("post_rst_rd", read_data, 32'h0000_0001);
    check("post_rst_route", {25'd0, get_out(0, 0)}, 32'h33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sb_disjoint_reg.md
Name: sb_disjoint_reg

Overview:
- Configurable disjoint switch box. It drives the routing tracks that connection boxes consume; its side outputs become the in_0..in_7 track inputs of the downstream connection box.
- Each output track on each side selects the same-numbered track from one of the other three sides. The selection is either combinational or through a per-track pipeline register.
- Configuration is written and read back over the tile config bus: config_addr, config_data, config_en, read_data.

Parameters:
- WIDTH, 7, bit width of one track.
- NUM_TRACKS, 8, tracks per side.
- NUM_WORDS, ceil(4*NUM_TRACKS*3/32), number of 32-bit config words (3 at defaults).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- config_addr  in  32  bits [7:0] = config word index; upper bits ignored.
- config_data  in  32  config write data.
- config_en  in  1  config write strobe.
- read_data  out  32  readback of the addressed config word.
- in_north, in_south, in_east, in_west  in  NUM_TRACKS*WIDTH each  track t occupies bits [t*WIDTH+WIDTH-1 : t*WIDTH].
- out_north, out_south, out_east, out_west  out  NUM_TRACKS*WIDTH each  same packing as the inputs.

Behaviour:
- Side codes: N=0, S=1, E=2, W=3. Output index o = side*NUM_TRACKS + track.
- Config vector cfg[32*NUM_WORDS-1:0]:
  - cfg[3o+1:3o] = sel for output o.
  - cfg[3o+2] = reg_en for output o.
  - Word k holds cfg[32k+31:32k]. Unused high bits are writable and read back as written.
- sel decode for an output on side S: candidates are the other three sides in ascending side code.
  - sel=0: lowest remaining side. sel=1: middle. sel=2: highest. sel=3: constant 0.
  - Example: out_north sel 0/1/2 = south/east/west. out_east sel 0/1/2 = north/south/west.
  - The track number is always preserved (disjoint topology).
- Config write: on a rising clk with config_en=1 and index < NUM_WORDS, word[index] <= config_data.
  - Index >= NUM_WORDS: write ignored.
- read_data is combinational: word[index], or 0 when index >= NUM_WORDS. Readback is independent of config_en.
- Pipeline register: one WIDTH-bit register per output. It captures the selected value on every rising clk, regardless of reg_en.
- Output paths:
  - reg_en=0: output = selected input, combinational (0 cycles).
  - reg_en=1: output = register value (1-cycle latency).
- Timing of config changes:
  - A config write takes effect on the output path immediately after the writing edge.
  - When reg_en goes 0->1, the output shows the value the register captured at that same edge (the new-or-old sel result, per the write-before-read ordering below).
- Simultaneous config write and register capture on the same edge: the register samples using the pre-edge config.
- Reset (reset=0, asynchronous):
  - All config words go to 0, so every output is sel=0 and combinational.
  - All pipeline registers go to 0.
  - read_data = 0 for every index.
  - This holds even if reset asserts mid-operation or during a config write; the write is lost.
- Release of reset is synchronous to the next clk edge. No register updates while reset=0.
- No X propagation from unused config bits; sel=3 forces exactly 0.

Test Plan:
- Reset: assert reset=0 with inputs 0 -> every read_data index 0..3 returns 0; registers = 0; out_north track 3 equals in_south track 3 once in_south track 3=5.
- Combinational route: write word0 = 0x1 (out_north track0 sel=1), in_east track0=4 -> out_north track0 = 4 in the same cycle; read_data at index 0 = 0x1.
- Registered route: write word0 = 0x6 (sel=2, reg_en=1), in_west track0=34 -> out_north track0 shows the old value until the next rising clk, then 34; change in_west track0 to 9 -> out_north track0 updates one cycle later.
- Readback and bounds:
  - Write word1 = 0x00070070 -> read_data at index 1 matches.
  - Write index 5 with 0xFFFFFFFF -> no config change; read index 5 = 0.
- Constant-zero select: set sel=3 for out_east track7 (word index/bit per mapping) with all inputs 0x7F -> out_east track7 = 0.
- Async reset mid-operation: with registered routes active and config_en=1, drop reset between clk edges -> outputs immediately revert to sel=0 combinational and all config reads = 0; after release, the next write behaves normally.
